// File: rtl/meter_pkg.sv
// Shared types and constants for the seconds countdown meter.
package meter_pkg;

  localparam int CNT_W = 14;
  localparam int BCD_W = 16;

  typedef enum logic {
    EXPIRED = 1'b0,
    RUN     = 1'b1
  } meter_state_e;

  localparam logic [CNT_W-1:0] ADD_SEC    [0:3] = '{14'd60, 14'd120, 14'd180, 14'd300};
  localparam logic [CNT_W-1:0] PRESET_SEC [0:1] = '{14'd15, 14'd150};
  localparam logic [CNT_W-1:0] LOW_WARN_SEC     = 14'd180;

endpackage

// File: rtl/meter_countdown_if.sv
// Request/status bundle between the meter and its controller/display stage.
interface meter_countdown_if;
  import meter_pkg::*;

  logic [3:0]       add_req;
  logic [1:0]       preset_req;
  logic [CNT_W-1:0] count_bin;
  logic [BCD_W-1:0] count_bcd;
  logic             expired;
  logic             low_warn;

  modport master (
    output add_req, preset_req,
    input  count_bin, count_bcd, expired, low_warn
  );

  modport slave (
    input  add_req, preset_req,
    output count_bin, count_bcd, expired, low_warn
  );
endinterface

// File: rtl/bin2bcd_14.sv
// Combinational 14-bit binary to 4-digit BCD conversion (shift-and-add-3).
module bin2bcd_14 (
  input  logic [13:0] bin,
  output logic [15:0] bcd
);

  logic [29:0] scratch;

  // NOTE: every variable assigned in always_comb gets a value first, so no path can infer a latch.
  always_comb begin
    scratch = {16'h0000, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (scratch[14+4*d +: 4] > 4'd4) begin
          scratch[14+4*d +: 4] = scratch[14+4*d +: 4] + 4'd3;
        end
      end
      scratch = scratch << 1;
    end
    bcd = scratch[29:14];
  end

endmodule

// File: rtl/meter_countdown.sv
// Saturating seconds countdown driven by a sampled 1 Hz slow_clk, with binary/BCD outputs.
// Optional low-time warning output enabled by defining METER_LOW_WARN_EN.
module meter_countdown
  import meter_pkg::*;
#(
  parameter int MAX_COUNT   = 9999,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  meter_countdown_if.slave bus
);

  localparam logic [CNT_W:0]   SUM_MAX = (CNT_W+1)'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   tick;
  meter_state_e           state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]       add_val;
  logic [CNT_W:0]         sum;
  logic [CNT_W-1:0]       clamped;

  // slow_clk is only ever treated as data: synchronise, then detect its rising edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk};
    edge_d = sync_q[SYNC_STAGES-1];
    tick   = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_comb begin
    add_val = '0;
    if (bus.add_req[0])      add_val = ADD_SEC[0];
    else if (bus.add_req[1]) add_val = ADD_SEC[1];
    else if (bus.add_req[2]) add_val = ADD_SEC[2];
    else if (bus.add_req[3]) add_val = ADD_SEC[3];

    // Clamp before any decrement so a saturated add on a tick lands at MAX_COUNT-1.
    sum     = {1'b0, count_q} + {1'b0, add_val};
    clamped = (sum > SUM_MAX) ? CNT_MAX : sum[CNT_W-1:0];

    count_d = count_q;
    if (|bus.preset_req) begin
      count_d = bus.preset_req[1] ? PRESET_SEC[1] : PRESET_SEC[0];
    end else if (|bus.add_req) begin
      count_d = (state_q == RUN && tick) ? clamped - ONE : clamped;
    end else if (tick && state_q == RUN) begin
      count_d = count_q - ONE;
    end

    state_d = (count_d == '0) ? EXPIRED : RUN;
  end

  bin2bcd_14 u_bin2bcd (
    .bin (count_q),
    .bcd (bcd_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      state_q <= EXPIRED;
      count_q <= '0;
      bcd_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      state_q <= state_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.count_bin = count_q;
  assign bus.count_bcd = bcd_q;
  assign bus.expired   = (state_q == EXPIRED);

`ifdef METER_LOW_WARN_EN
  logic low_warn_q, low_warn_d;

  always_comb begin
    low_warn_d = (count_d != '0) && (count_d < LOW_WARN_SEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) low_warn_q <= 1'b0;
    else        low_warn_q <= low_warn_d;
  end

  assign bus.low_warn = low_warn_q;
`else
  assign bus.low_warn = 1'b0;
`endif

endmodule
